// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port, registered-read data memory.
// Priority moves to the other port after MAX_BURST grants while it waits, or whenever only it requests.
module dmem_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

  typedef enum logic {OWN_A, OWN_B} state_t;

  state_t           state_q, state_d, state_oth;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d, burst_inc;
  logic             rvalid_a_q, rvalid_b_q;
  logic             pri_gnt, oth_gnt, oth_req;

  assign gnt_a = rst_n & req_a & (~req_b | (state_q == OWN_A));
  assign gnt_b = rst_n & req_b & (~req_a | (state_q == OWN_B));

  // Idle cycles still present addr_a so the memory does a harmless read.
  assign mem_we    = (gnt_a & we_a) | (gnt_b & we_b);
  assign mem_addr  = gnt_b ? addr_b : addr_a;
  assign mem_wdata = gnt_b ? wdata_b : wdata_a;

  assign state_oth = (state_q == OWN_A) ? OWN_B : OWN_A;
  assign pri_gnt   = (state_q == OWN_A) ? gnt_a : gnt_b;
  assign oth_gnt   = (state_q == OWN_A) ? gnt_b : gnt_a;
  assign oth_req   = (state_q == OWN_A) ? req_b : req_a;
  assign burst_inc = burst_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    if (pri_gnt) begin
      if (!oth_req) begin
        burst_cnt_d = '0;
      end else if (burst_inc == BURST_LIM) begin
        state_d     = state_oth;
        burst_cnt_d = '0;
      end else begin
        burst_cnt_d = burst_inc;
      end
    end else if (oth_gnt) begin
      state_d     = state_oth;
      burst_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= OWN_A;
      burst_cnt_q <= '0;
      rvalid_a_q  <= 1'b0;
      rvalid_b_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      rvalid_a_q  <= gnt_a & ~we_a;
      rvalid_b_q  <= gnt_b & ~we_b;
    end
  end

  // Masking with rst_n hides a read return whose cycle is cut short by reset.
  assign rvalid_a = rvalid_a_q & rst_n;
  assign rvalid_b = rvalid_b_q & rst_n;
  assign rdata_a  = mem_rdata;
  assign rdata_b  = mem_rdata;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port, registered-read data memory (`data_mem`) between two requesters: port A, the core load/store path, and port B, the loader/debug path. Each cycle the arbiter grants at most one request using round-robin with a bounded burst. It drives the memory's write enable, address and write data, and returns read data with a one-cycle-delayed valid strobe to the port that issued the read. It sits between the requesters and `data_mem` and adds no latency beyond the memory's own one-cycle read.

## Interface
Parameters:
- MAX_BURST, default 4: maximum consecutive grants the priority port receives while the other port is waiting. Legal range is 1..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req_a / req_b  in  1  request valid. Held with its payload until granted.
- we_a / we_b  in  1  1 = write, 0 = read.
- addr_a / addr_b  in  address_t  word address.
- wdata_a / wdata_b  in  word_t  write data.
- gnt_a / gnt_b  out  1  combinational. High means the request is accepted at this rising edge.
- rvalid_a / rvalid_b  out  1  registered. Pulses one cycle after a granted read.
- rdata_a / rdata_b  out  word_t  both driven from mem_rdata. Valid only while the matching rvalid is high.
- mem_we  out  1  to data_mem write_enable.
- mem_addr  out  address_t  to data_mem data_address.
- mem_wdata  out  word_t  to data_mem write_data.
- mem_rdata  in  word_t  from data_mem read_data.

## Operation
- FSM state: OWN_A or OWN_B, naming the priority port. Counter `burst_cnt` is $clog2(MAX_BURST+1) bits wide.
- Grant, combinational:
  - Only one port requesting: that port is granted.
  - Both requesting: the priority port is granted.
  - Neither requesting: no grant.
  - gnt_a and gnt_b are never both high.
- Memory mux:
  - A port is granted: mem_addr, mem_wdata and mem_we come from that port, with mem_we = we of the granted port.
  - No grant: mem_we = 0 and mem_addr = addr_a, so data_mem performs a harmless read.
- FSM update on each rising edge, with X the priority port and Y the other port:
  - X granted while req_Y is high: burst_cnt + 1. If the result equals MAX_BURST, go to OWN_Y and clear burst_cnt to 0. Otherwise stay.
  - X granted while req_Y is low: stay, burst_cnt = 0.
  - Y granted (req_X low): go to OWN_Y, burst_cnt = 0.
  - No grant: hold state and burst_cnt.
- Read return:
  - A read granted to port P at edge n gives rvalid_P = 1 for the cycle after edge n. rdata_P = mem_rdata in that cycle.
  - A write grant produces no rvalid.
  - Back-to-back reads produce back-to-back rvalid pulses, alternating ports when grants alternate.
- A write immediately after a read does not disturb the earlier read's return.
  - data_mem updates read_data only on read cycles.
  - The read's data is already captured at the edge where it was granted.

## Timing
- Reset, with rst_n low at a rising edge:
  - State = OWN_A, burst_cnt = 0, rvalid_a = rvalid_b = 0.
  - While rst_n is low, gnt_a = gnt_b = 0 and mem_we = 0, regardless of requests.
- Reset in the middle of a read (read granted at edge n, rst_n low at edge n+1): the rvalid that would follow is suppressed and stays 0.
- Throughput is one transaction per cycle. Read latency from grant is 1 cycle.
- Port requirements:
  - Request payload must be stable while req is high and gnt is low.
  - req may be deasserted only after the grant edge.
  - Deassertion without a grant is illegal.
- Starvation bound: with both ports requesting continuously, the non-priority port waits at most MAX_BURST cycles.
- With MAX_BURST = 1 and both ports requesting, grants alternate strictly A, B, A, B.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles with req_a = req_b = 1. Required: gnt_a = gnt_b = 0, mem_we = 0, rvalid_a = rvalid_b = 0. On release, A is granted first.
- Single-port write then read: A writes 0xDEADBEEF to address 5, then reads address 5. Required: gnt_a high on both cycles, and rvalid_a with rdata_a = 0xDEADBEEF in the cycle after the read grant. rvalid_b stays 0.
- Burst fairness, MAX_BURST = 4, both ports requesting reads continuously. Required grant sequence: A, A, A, A, B, B, B, B, A, and so on. Each rvalid follows its grant by exactly 1 cycle to the correct port.
- Strict alternation, MAX_BURST = 1, both requesting. Required: gnt alternates A, B, A, B. Port B's read of address 7 (preloaded 0x11) returns 0x11 on rvalid_b only.
- Idle priority handoff: from OWN_A, only B requests for 2 cycles, then both request. Required: B is granted on all three cycles (priority passed to B).
- Read then write collision: A reads address 3 (value 0xAA), then B immediately writes 0x55 to address 3. Required: rvalid_a returns 0xAA, and a later read of address 3 returns 0x55.
